// File: rtl/v_trace_buf.sv
// -----------------------------------------------------------------------------
// v_trace_buf -- multi-channel event-trace capture buffer.
//
// Samples CH_N event streams, stamps each event with the free-running cycle
// count, holds it in a one-deep per-channel stage, arbitrates the stages
// round-robin into a single FIFO and drains the FIFO through a valid/ready
// port. Every event that cannot be staged is counted in a saturating counter.
//
// Optional feature (compile-time macro V_TRACE_BUF_FILTER_EN):
//   defined   -> adds i_flt_vld / i_flt_id; while i_flt_vld=1 only events
//                whose id equals i_flt_id enter a stage (others are discarded
//                silently, not counted as drops).
//   undefined -> no filter ports, every enabled event is captured.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous reset, active-low
//   i_en          in   capture enable (0: new events ignored, drain continues)
//   i_ev_vld      in   [CH_N]            per-channel event strobe
//   i_ev_id       in   [CH_N*ID_W]       per-channel product id
//   i_ev_payload  in   [CH_N*PAYLOAD_W]  per-channel payload
//   o_tr_vld_r    out  trace head valid (registered)
//   o_tr_ch       out  head channel index
//   o_tr_id       out  head product id
//   o_tr_payload  out  head payload
//   o_tr_ts       out  head timestamp
//   i_tr_rdy      in   consumer ready
//   o_full_r      out  FIFO full (registered)
//   o_drop_cnt_r  out  saturating lost-event count
//   o_ts_r        out  free-running cycle counter
//   i_flt_vld     in   filter active            (V_TRACE_BUF_FILTER_EN only)
//   i_flt_id      in   [ID_W] id to keep        (V_TRACE_BUF_FILTER_EN only)
// -----------------------------------------------------------------------------
module v_trace_buf #(
    parameter int CH_N      = 3,
    parameter int ID_W      = 8,
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 32,
    parameter int DROP_W    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_en,
    input  logic [CH_N-1:0]                           i_ev_vld,
    input  logic [CH_N*ID_W-1:0]                      i_ev_id,
    input  logic [CH_N*PAYLOAD_W-1:0]                 i_ev_payload,
    output logic                                      o_tr_vld_r,
    output logic [((CH_N > 1) ? $clog2(CH_N) : 1)-1:0] o_tr_ch,
    output logic [ID_W-1:0]                           o_tr_id,
    output logic [PAYLOAD_W-1:0]                      o_tr_payload,
    output logic [TS_W-1:0]                           o_tr_ts,
    input  logic                                      i_tr_rdy,
    output logic                                      o_full_r,
    output logic [DROP_W-1:0]                         o_drop_cnt_r,
`ifdef V_TRACE_BUF_FILTER_EN
    input  logic                                      i_flt_vld,
    input  logic [ID_W-1:0]                           i_flt_id,
`endif
    output logic [TS_W-1:0]                           o_ts_r
);

    localparam int CH_W = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Free-running timestamp
    logic [TS_W-1:0]      ts_r;

    // Per-channel stage registers
    logic [CH_N-1:0]      stg_vld_r;
    logic [ID_W-1:0]      stg_id_r  [CH_N];
    logic [PAYLOAD_W-1:0] stg_pl_r  [CH_N];
    logic [TS_W-1:0]      stg_ts_r  [CH_N];

    // Arbiter
    logic [CH_W-1:0]      rr_ptr_r;
    logic [CH_W:0]        cand_s;
    logic                 gnt_vld_s;
    logic [CH_W-1:0]      gnt_idx_s;
    logic [CH_N-1:0]      gnt_oh_s;

    // Capture / drop accounting
    logic [CH_N-1:0]      accept_s;
    logic [CH_N-1:0]      drop_s;
    logic [3:0]           drop_sum_s;
    logic [DROP_W+3:0]    drop_ext_s;
    logic [DROP_W-1:0]    drop_nxt_s;
    logic [DROP_W-1:0]    drop_cnt_r;

    // FIFO storage and control
    logic [CH_W-1:0]      mem_ch [DEPTH];
    logic [ID_W-1:0]      mem_id [DEPTH];
    logic [PAYLOAD_W-1:0] mem_pl [DEPTH];
    logic [TS_W-1:0]      mem_ts [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          cnt_r;
    logic [AW:0]          cnt_nxt_s;
    logic                 vld_r;
    logic                 full_r;
    logic                 pop_s;
    logic                 can_push_s;

    // A slot frees up either because the FIFO is not full or because the
    // head leaves in the same cycle (push+pop while full keeps the count).
    assign pop_s      = vld_r & i_tr_rdy;
    assign can_push_s = ~full_r | pop_s;
    assign cnt_nxt_s  = cnt_r + (AW+1)'(gnt_vld_s) - (AW+1)'(pop_s);

    // Event acceptance: enable plus optional id filter
    always_comb begin
        accept_s = '0;
        for (int c = 0; c < CH_N; c++) begin
`ifdef V_TRACE_BUF_FILTER_EN
            accept_s[c] = i_ev_vld[c] & i_en &
                          (~i_flt_vld | (i_ev_id[c*ID_W +: ID_W] == i_flt_id));
`else
            accept_s[c] = i_ev_vld[c] & i_en;
`endif
        end
    end

    // Round-robin search over occupied stages starting at rr_ptr_r
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int i = 0; i < CH_N; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (CH_W+1)'(i);
            if (cand_s >= (CH_W+1)'(CH_N)) begin
                cand_s = cand_s - (CH_W+1)'(CH_N);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_vld_s && can_push_s && stg_vld_r[cand_s[CH_W-1:0]]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = cand_s[CH_W-1:0];
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    // Grant one-hot and per-channel drop detection; a stage that is granted
    // this cycle may be reloaded without loss.
    always_comb begin
        gnt_oh_s   = '0;
        drop_s     = '0;
        drop_sum_s = 4'd0;
        for (int c = 0; c < CH_N; c++) begin
            gnt_oh_s[c] = gnt_vld_s & (gnt_idx_s == CH_W'(c));
            drop_s[c]   = accept_s[c] & stg_vld_r[c] & ~gnt_oh_s[c];
            drop_sum_s  = drop_sum_s + {3'b000, drop_s[c]};
        end
    end

    // Saturating add of this cycle's drops
    always_comb begin
        drop_ext_s = {4'b0000, drop_cnt_r} + {{DROP_W{1'b0}}, drop_sum_s};
        if (drop_ext_s[DROP_W+3:DROP_W] != 4'b0000) begin
            drop_nxt_s = {DROP_W{1'b1}};
        end else begin
            drop_nxt_s = drop_ext_s[DROP_W-1:0];
        end
    end

    // Timestamp counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // Stage registers: load on accepted event when free or leaving this cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_vld_r <= '0;
            for (int c = 0; c < CH_N; c++) begin
                stg_id_r[c] <= '0;
                stg_pl_r[c] <= '0;
                stg_ts_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH_N; c++) begin
                if (accept_s[c] && (!stg_vld_r[c] || gnt_oh_s[c])) begin
                    stg_vld_r[c] <= 1'b1;
                    stg_id_r[c]  <= i_ev_id[c*ID_W +: ID_W];
                    stg_pl_r[c]  <= i_ev_payload[c*PAYLOAD_W +: PAYLOAD_W];
                    stg_ts_r[c]  <= ts_r;
                end else if (gnt_oh_s[c]) begin
                    stg_vld_r[c] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances past the granted channel
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else if (gnt_vld_s) begin
            if (gnt_idx_s == CH_W'(CH_N - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx_s + CH_W'(1);
            end
        end
    end

    // FIFO storage and pointers; storage is cleared so the head is never X
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ch[i] <= '0;
                mem_id[i] <= '0;
                mem_pl[i] <= '0;
                mem_ts[i] <= '0;
            end
        end else begin
            if (gnt_vld_s) begin
                mem_ch[wr_ptr_r] <= gnt_idx_s;
                mem_id[wr_ptr_r] <= stg_id_r[gnt_idx_s];
                mem_pl[wr_ptr_r] <= stg_pl_r[gnt_idx_s];
                mem_ts[wr_ptr_r] <= stg_ts_r[gnt_idx_s];
                wr_ptr_r         <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            cnt_r <= cnt_nxt_s;
        end
    end

    // Registered status flags and drop counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_r      <= 1'b0;
            full_r     <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            vld_r      <= (cnt_nxt_s != '0);
            full_r     <= (cnt_nxt_s == (AW+1)'(DEPTH));
            drop_cnt_r <= drop_nxt_s;
        end
    end

    assign o_tr_vld_r   = vld_r;
    assign o_full_r     = full_r;
    assign o_drop_cnt_r = drop_cnt_r;
    assign o_ts_r       = ts_r;
    assign o_tr_ch      = mem_ch[rd_ptr_r];
    assign o_tr_id      = mem_id[rd_ptr_r];
    assign o_tr_payload = mem_pl[rd_ptr_r];
    assign o_tr_ts      = mem_ts[rd_ptr_r];

endmodule

// File: tb/tb_v_trace_buf.sv
// -----------------------------------------------------------------------------
// tb_v_trace_buf -- scoreboard bench for v_trace_buf (CH_N=3, DEPTH=16).
// Stimulus pushes the expected trace entries into a queue; an independent
// monitor compares the head against the queue front on every falling edge
// while o_tr_vld_r is high and retires the entry when it is handed over.
// -----------------------------------------------------------------------------
module tb_v_trace_buf;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  id;
        logic [63:0] pl;
        logic [31:0] ts;
    } ent_t;

    logic         clk;
    logic         rst;
    logic         i_en;
    logic [2:0]   i_ev_vld;
    logic [23:0]  i_ev_id;
    logic [191:0] i_ev_payload;
    logic         o_tr_vld_r;
    logic [1:0]   o_tr_ch;
    logic [7:0]   o_tr_id;
    logic [63:0]  o_tr_payload;
    logic [31:0]  o_tr_ts;
    logic         i_tr_rdy;
    logic         o_full_r;
    logic [15:0]  o_drop_cnt_r;
    logic [31:0]  o_ts_r;
`ifdef V_TRACE_BUF_FILTER_EN
    logic         i_flt_vld;
    logic [7:0]   i_flt_id;
`endif

    int   n_chk;
    int   n_fail;
    int   n_pop;
    int   pop_base;
    ent_t sb_q[$];
    ent_t exp_e;
    logic [31:0] tb_ts;

    v_trace_buf dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_ev_vld     (i_ev_vld),
        .i_ev_id      (i_ev_id),
        .i_ev_payload (i_ev_payload),
        .o_tr_vld_r   (o_tr_vld_r),
        .o_tr_ch      (o_tr_ch),
        .o_tr_id      (o_tr_id),
        .o_tr_payload (o_tr_payload),
        .o_tr_ts      (o_tr_ts),
        .i_tr_rdy     (i_tr_rdy),
        .o_full_r     (o_full_r),
        .o_drop_cnt_r (o_drop_cnt_r),
`ifdef V_TRACE_BUF_FILTER_EN
        .i_flt_vld    (i_flt_vld),
        .i_flt_id     (i_flt_id),
`endif
        .o_ts_r       (o_ts_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench cycle count: 0 on the reset edge, +1 on every later edge
    always @(posedge clk) begin
        if (!rst) tb_ts <= 32'd0;
        else      tb_ts <= tb_ts + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: head must match queue front while valid; retire on handshake
    always @(negedge clk) begin
        if (o_tr_vld_r === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got id %0h ch %0d, expected no output", o_tr_id, o_tr_ch);
            end else begin
                exp_e = sb_q[0];
                chk("out_ch", {62'd0, o_tr_ch}, {62'd0, exp_e.ch});
                chk("out_id", {56'd0, o_tr_id}, {56'd0, exp_e.id});
                chk("out_payload", o_tr_payload, exp_e.pl);
                chk("out_ts", {32'd0, o_tr_ts}, {32'd0, exp_e.ts});
                if (i_tr_rdy) begin
                    void'(sb_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_ev_vld = 3'b000;
    endtask

    task automatic set_ev(input int c, input logic [7:0] id, input logic [63:0] pl);
        i_ev_vld[c]            = 1'b1;
        i_ev_id[c*8 +: 8]      = id;
        i_ev_payload[c*64 +: 64] = pl;
    endtask

    task automatic exp_push(input int c, input logic [7:0] id, input logic [63:0] pl, input logic [31:0] ts);
        ent_t e;
        e.ch = 2'(c);
        e.id = id;
        e.pl = pl;
        e.ts = ts;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input string name, input int max_cyc);
        for (int k = 0; k < max_cyc && sb_q.size() != 0; k++) step();
        @(negedge clk);
        chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({name, "_vld_low"}, {63'd0, o_tr_vld_r}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; n_pop = 0;
        rst = 1'b0; i_en = 1'b1; i_tr_rdy = 1'b1;
        i_ev_vld = '0; i_ev_id = '0; i_ev_payload = '0;
`ifdef V_TRACE_BUF_FILTER_EN
        i_flt_vld = 1'b0; i_flt_id = 8'd0;
`endif
        step();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_vld", {63'd0, o_tr_vld_r}, 64'd0);
        chk("rst_full", {63'd0, o_full_r}, 64'd0);
        chk("rst_drop", {48'd0, o_drop_cnt_r}, 64'd0);
        chk("rst_ts", {32'd0, o_ts_r}, 64'd0);
        chk("rst_payload", o_tr_payload, 64'd0);

        // Single event at ts=10: valid two edges later, popped next edge
        repeat (10) step();
        chk("ts_count", {32'd0, o_ts_r}, 64'd10);
        set_ev(0, 8'd5, 64'hAB);
        exp_push(0, 8'd5, 64'hAB, 32'd10);
        step();
        @(negedge clk);
        chk("lat_e0_vld", {63'd0, o_tr_vld_r}, 64'd0);
        step();
        @(negedge clk);
        chk("lat_e1_vld", {63'd0, o_tr_vld_r}, 64'd1);
        step();
        @(negedge clk);
        chk("lat_pop_vld", {63'd0, o_tr_vld_r}, 64'd0);
        chk("lat_sb_empty", 64'(sb_q.size()), 64'd0);

        // Three-channel bursts: order ch0,ch1,ch2 both times
        step();
        do_reset();
        repeat (3) step();
        set_ev(0, 8'h10, 64'h1000); set_ev(1, 8'h11, 64'h1001); set_ev(2, 8'h12, 64'h1002);
        exp_push(0, 8'h10, 64'h1000, tb_ts);
        exp_push(1, 8'h11, 64'h1001, tb_ts);
        exp_push(2, 8'h12, 64'h1002, tb_ts);
        step();
        repeat (6) step();
        set_ev(0, 8'h20, 64'h2000); set_ev(1, 8'h21, 64'h2001); set_ev(2, 8'h22, 64'h2002);
        exp_push(0, 8'h20, 64'h2000, tb_ts);
        exp_push(1, 8'h21, 64'h2001, tb_ts);
        exp_push(2, 8'h22, 64'h2002, tb_ts);
        step();
        drain("burst", 20);

        // Capture disabled: event ignored, no drop
        step();
        i_en = 1'b0;
        set_ev(2, 8'h33, 64'h3333);
        step();
        i_en = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("en_off_vld", {63'd0, o_tr_vld_r}, 64'd0);
        chk("en_off_drop", {48'd0, o_drop_cnt_r}, 64'd0);

        // Overflow: 20 back-to-back ch0 events with consumer stalled
        step();
        i_tr_rdy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            set_ev(0, 8'(k), 64'h5000 + 64'(k));
            if (k <= 17) exp_push(0, 8'(k), 64'h5000 + 64'(k), tb_ts);
            step();
        end
        repeat (2) step();
        @(negedge clk);
        chk("ovf_full", {63'd0, o_full_r}, 64'd1);
        chk("ovf_drop", {48'd0, o_drop_cnt_r}, 64'd3);
        chk("ovf_vld", {63'd0, o_tr_vld_r}, 64'd1);

        // Push+pop while full, with the stage reloaded in the same cycle
        pop_base = n_pop;
        step();
        i_tr_rdy = 1'b1;
        set_ev(0, 8'd21, 64'h5000 + 64'd21);
        exp_push(0, 8'd21, 64'h5000 + 64'd21, tb_ts);
        step();
        i_tr_rdy = 1'b0;
        @(negedge clk);
        chk("pp_full", {63'd0, o_full_r}, 64'd1);
        chk("pp_drop", {48'd0, o_drop_cnt_r}, 64'd3);
        step();
        i_tr_rdy = 1'b1;
        drain("ovf", 40);
        chk("ovf_pop_count", 64'(n_pop - pop_base), 64'd18);

        // Reset with 8 entries queued
        step();
        i_tr_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_ev(1, 8'h40 + 8'(k), 64'h6000 + 64'(k));
            exp_push(1, 8'h40 + 8'(k), 64'h6000 + 64'(k), tb_ts);
            step();
        end
        repeat (3) step();
        @(negedge clk);
        chk("q8_vld", {63'd0, o_tr_vld_r}, 64'd1);
        chk("q8_full", {63'd0, o_full_r}, 64'd0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("mrst_vld", {63'd0, o_tr_vld_r}, 64'd0);
        chk("mrst_full", {63'd0, o_full_r}, 64'd0);
        chk("mrst_drop", {48'd0, o_drop_cnt_r}, 64'd0);
        chk("mrst_ts", {32'd0, o_ts_r}, 64'd0);
        step();
        i_tr_rdy = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("mrst_stay_empty", {63'd0, o_tr_vld_r}, 64'd0);

`ifdef V_TRACE_BUF_FILTER_EN
        // Filter on id 7: only the ch1 event survives, nothing counted
        step();
        i_flt_vld = 1'b1;
        i_flt_id  = 8'd7;
        set_ev(0, 8'd3, 64'h7003); set_ev(1, 8'd7, 64'h7007); set_ev(2, 8'd9, 64'h7009);
        exp_push(1, 8'd7, 64'h7007, tb_ts);
        step();
        drain("filter", 20);
        chk("filter_drop", {48'd0, o_drop_cnt_r}, 64'd0);
        step();
        i_flt_vld = 1'b0;
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
